dbg_com_apb_arbiter: RTL and testbench
======================================

// Module: dbg_com_apb_arbiter
// PURPOSE
//  Shares the single debug-globals APB "com" slave port between NREQ host-side requesters
//  (e.g. JTAG-DTM bridge, UART console bridge). Grants one requester per transfer,
//  round-robin. Drives the APB setup/access phases and returns read data, error and
//  completion to the granted requester. Sits between the host bridges and the globals
//  register block that owns debug reset/power/GPIO.
// PARAMETERS
//  NREQ         2    number of requesters, 2..8
//  TIMEOUT_CYC  255  max ACCESS cycles waiting for pready before forced abort, 1..65535
// PORTS
//  clk_i          in   1         clock
//  rst_i          in   1         synchronous reset, active-high
//  req_i          in   NREQ      per-requester request level
//  addr_i         in   NREQ*32   per-requester address, requester k at [32k+:32]
//  wdata_i        in   NREQ*48   per-requester write data, [48k+:48]
//  write_i        in   NREQ      per-requester direction, 1=write
//  done_o         out  NREQ      one-cycle completion pulse to the owning requester
//  rdata_o        out  48        read data for the completing transfer, shared
//  err_o          out  1         error flag for the completing transfer, valid with done_o
//  busy_o         out  1         transfer in progress (state != IDLE)
//  psel_com_o     out  1         APB select
//  penable_com_o  out  1         APB enable
//  paddr_com_o    out  32        APB address
//  pwdata_com_o   out  48        APB write data
//  pwrite_com_o   out  1         APB direction
//  prdata_com_i   in   48        APB read data
//  pready_com_i   in   1         APB ready
//  pslverr_com_i  in   1         APB slave error
// BEHAVIOUR
//  Reset (rst_i=1 at clock edge): state=IDLE. done_o=0, rdata_o=0, err_o=0, busy_o=0.
//   psel/penable/pwrite=0, paddr=0, pwdata=0. RR pointer=NREQ-1, so requester 0 wins first.
//   Reset mid-transfer drops psel the next edge. No done_o is issued for the aborted transfer.
//  FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE. All outputs are registered.
//   IDLE: when any req_i is set, choose the winner by round-robin: scan from ptr+1 upward,
//    with wrap. Latch the winner's addr/wdata/write into paddr/pwdata/pwrite. Set ptr=winner.
//    Go to SETUP.
//   SETUP (1 cycle): psel=1, penable=0. Go to ACCESS.
//   ACCESS: psel=1, penable=1. Clear the wait counter on entry. Each cycle:
//    - pready_com_i=1: capture rdata = pwrite ? 0 : prdata_com_i, and err = pslverr_com_i.
//      Go to DONE.
//    - else, counter==TIMEOUT_CYC-1: abort with rdata=0, err=1. Go to DONE.
//    - else counter++. The counter is 16 bits and saturates; it never wraps.
//   DONE (1 cycle): psel=0, penable=0, done_o[owner]=1, rdata_o/err_o valid. Go to IDLE.
//    rdata_o/err_o hold their value until the next DONE.
//  Latency: req_i sampled high in IDLE at edge N gives psel=1 after N, penable=1 after N+1.
//   With zero wait states, pready is sampled at N+2 and done_o is high after N+2 for 1 cycle.
//   Minimum 4 cycles per transfer. A requester that keeps req_i high is re-arbitrated in the
//   next IDLE cycle.
//  Requester rules: hold addr/wdata/write stable while req_i is high. Payload is latched
//   only in IDLE; later changes are ignored. Dropping req_i mid-transfer does not cancel it;
//   done_o still pulses.
//  Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NREQ-1,0.
//   No requester waits more than NREQ-1 transfers.
//  paddr/pwdata/pwrite stay constant from SETUP through ACCESS and are not cleared in DONE.
//  Requests not granted are ignored until IDLE. No queueing, no pre-arbitration.
// TESTING
//  1 Req0 write addr=0x18 wdata=0xA5A5_5A5A, pready tied 1 -> psel 2 cycles, penable 1 cycle,
//    pwdata=0xA5A5_5A5A, done_o=01 at cycle 3, err_o=0, rdata_o=0.
//  2 Req1 read addr=0x04, slave returns 0x1234_5678 after 3 wait states -> penable high
//    4 cycles, done_o=10, rdata_o=0x1234_5678.
//  3 req_i=11 held for 4 transfers -> grant order 0,1,0,1, each with its own address on
//    paddr. done_o alternates 01,10,01,10.
//  4 TIMEOUT_CYC=8, pready held 0 -> penable high exactly 8 cycles, then done_o pulse with
//    err_o=1, rdata_o=0. Next request proceeds normally.
//  5 pready=1 with pslverr=1 on a read of 0x1C -> err_o=1 and rdata_o=prdata_com_i,
//    both with done_o.
//  6 rst_i pulsed in ACCESS -> psel/penable=0 next edge, no done_o. Next grant goes to
//    requester 0.

Source files
------------

// File: rtl/dbg_com_apb_arbiter.sv
// rtl/dbg_com_apb_arbiter.sv - round-robin arbiter sharing the debug-globals APB com port
module dbg_com_apb_arbiter #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*32-1:0]   addr_i,
    input  logic [NREQ*48-1:0]   wdata_i,
    input  logic [NREQ-1:0]      write_i,
    output logic [NREQ-1:0]      done_o,
    output logic [47:0]          rdata_o,
    output logic                 err_o,
    output logic                 busy_o,
    output logic                 psel_com_o,
    output logic                 penable_com_o,
    output logic [31:0]          paddr_com_o,
    output logic [47:0]          pwdata_com_o,
    output logic                 pwrite_com_o,
    input  logic [47:0]          prdata_com_i,
    input  logic                 pready_com_i,
    input  logic                 pslverr_com_i
);
    localparam int              PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              SW      = PW + 1;
    localparam logic [SW-1:0]   NREQ_W  = SW'(NREQ);
    localparam logic [PW-1:0]   PTR_RST = PW'(NREQ - 1);
    localparam logic [15:0]     TO_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [31:0]     paddr_q, paddr_d;
    logic [47:0]     pwdata_q, pwdata_d;
    logic            pwrite_q, pwrite_d;
    logic [47:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] done_q, done_d;

    logic            found;
    logic [PW-1:0]   winner;
    logic [SW-1:0]   scan;

    // Scan upward from the last owner so the previous winner is considered last.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        scan   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            scan = {1'b0, ptr_q} + SW'(i);
            if (scan >= NREQ_W) begin
                scan = scan - NREQ_W;
            end
            if (!found && req_i[scan[PW-1:0]]) begin
                found  = 1'b1;
                winner = scan[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    ptr_d    = winner;
                    paddr_d  = addr_i[32*winner +: 32];
                    pwdata_d = wdata_i[48*winner +: 48];
                    pwrite_d = write_i[winner];
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready_com_i) begin
                    rdata_d = pwrite_q ? 48'd0 : prdata_com_i;
                    err_d   = pslverr_com_i;
                    state_d = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d = (state_d == S_ACCESS);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE) ? (NREQ'(1) << ptr_d) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_RST;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign done_o        = done_q;
    assign rdata_o       = rdata_q;
    assign err_o         = err_q;
    assign busy_o        = busy_q;
    assign psel_com_o    = psel_q;
    assign penable_com_o = penable_q;
    assign paddr_com_o   = paddr_q;
    assign pwdata_com_o  = pwdata_q;
    assign pwrite_com_o  = pwrite_q;

endmodule

// File: tb/tb_dbg_com_apb_arbiter.sv
// tb/tb_dbg_com_apb_arbiter.sv - bench for dbg_com_apb_arbiter with a round-robin reference model
module tb_dbg_com_apb_arbiter;
    localparam int NREQ = 2;
    localparam int TO   = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*32-1:0]   addr;
    logic [NREQ*48-1:0]   wdata;
    logic [NREQ-1:0]      write;
    logic [NREQ-1:0]      done;
    logic [47:0]          rdata;
    logic                 err;
    logic                 busy;
    logic                 psel;
    logic                 penable;
    logic [31:0]          paddr;
    logic [47:0]          pwdata;
    logic                 pwrite;
    logic [47:0]          prdata;
    logic                 pready;
    logic                 pslverr;

    int tests_run    = 0;
    int tests_failed = 0;
    int ptr_m;

    always #5 clk = ~clk;

    dbg_com_apb_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .wdata_i(wdata),
        .write_i(write), .done_o(done), .rdata_o(rdata), .err_o(err), .busy_o(busy),
        .psel_com_o(psel), .penable_com_o(penable), .paddr_com_o(paddr),
        .pwdata_com_o(pwdata), .pwrite_com_o(pwrite), .prdata_com_i(prdata),
        .pready_com_i(pready), .pslverr_com_i(pslverr)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference arbitration: first requester after the last owner, wrapping.
    function automatic int rr_pick(input int p, input logic [NREQ-1:0] r);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (p + k) % NREQ;
            if (((r >> idx) & NREQ'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    // Plays the APB slave for one transfer and reports what was observed.
    task automatic xfer(input int waits, input logic [47:0] rd, input logic serr,
                        input logic scram, input logic [NREQ-1:0] drop,
                        output logic seen, output int lat, output logic [31:0] a,
                        output logic [47:0] wd, output logic w, output int nsel,
                        output int nen, output logic [NREQ-1:0] dn,
                        output logic [47:0] r, output logic e, output logic stable);
        int guard;
        seen = 1'b0; lat = 0; a = '0; wd = '0; w = 1'b0; nsel = 0; nen = 0;
        dn = '0; r = '0; e = 1'b0; stable = 1'b1;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        do begin
            @(negedge clk);
            lat++;
        end while (psel !== 1'b1 && lat < 20);
        if (psel !== 1'b1) return;
        a = paddr; wd = pwdata; w = pwrite; nsel = 1;
        if (penable === 1'b1) nen++;
        if (scram) begin
            req   = req & ~drop;
            addr  = {$urandom, $urandom};
            wdata = {$urandom, $urandom, $urandom};
            write = NREQ'($urandom);
        end
        prdata = rd; pslverr = serr;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (psel === 1'b1) begin
                nsel++;
                if (paddr !== a || pwdata !== wd || pwrite !== w) stable = 1'b0;
            end
            if (penable === 1'b1) nen++;
            pready = (nen >= waits + 1);
        end while (done === '0 && guard < 40);
        pready = 1'b0; pslverr = 1'b0;
        seen = (done !== '0);
        dn = done; r = rdata; e = err;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b11; addr = {$urandom, $urandom};
        wdata = {$urandom, $urandom, $urandom}; write = 2'b11;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        repeat (3) @(negedge clk);
        tests_run++; if ({psel, penable, pwrite, err, busy} !== 5'b0) begin tests_failed++; $display("FAIL reset_ctrl: got %b expected 00000", {psel, penable, pwrite, err, busy}); end
        tests_run++; if (paddr !== 32'd0) begin tests_failed++; $display("FAIL reset_paddr: got %h expected 0", paddr); end
        tests_run++; if (pwdata !== 48'd0) begin tests_failed++; $display("FAIL reset_pwdata: got %h expected 0", pwdata); end
        tests_run++; if (done !== '0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (rdata !== 48'd0) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        req = '0; rst = 1'b0;
        ptr_m = NREQ - 1;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_write_zero_wait();
        logic seen, w, e, st; int lat, nsel, nen; logic [31:0] a; logic [47:0] wd, r; logic [NREQ-1:0] dn;
        req = 2'b01; addr[31:0] = 32'h18; wdata[47:0] = 48'hA5A5_5A5A; write = 2'b01;
        xfer(0, 48'h0BAD_0BAD_0BAD, 1'b0, 1'b0, '0, seen, lat, a, wd, w, nsel, nen, dn, r, e, st);
        req = '0; ptr_m = 0;
        tests_run++; if (seen !== 1'b1 || lat != 1) begin tests_failed++; $display("FAIL wr_latency: seen %b lat %0d expected seen 1 lat 1", seen, lat); end
        tests_run++; if (nsel != 2 || nen != 1) begin tests_failed++; $display("FAIL wr_phases: psel %0d penable %0d expected 2 1", nsel, nen); end
        tests_run++; if (a !== 32'h18 || wd !== 48'hA5A5_5A5A || w !== 1'b1) begin tests_failed++; $display("FAIL wr_payload: got %h %h %b expected 18 a5a55a5a 1", a, wd, w); end
        tests_run++; if (dn !== 2'b01 || e !== 1'b0 || r !== 48'd0) begin tests_failed++; $display("FAIL wr_done: got %b %b %h expected 01 0 0", dn, e, r); end
    endtask

    task automatic test_wait_read();
        logic seen, w, e, st; int lat, nsel, nen; logic [31:0] a; logic [47:0] wd, r; logic [NREQ-1:0] dn;
        req = 2'b10; addr[63:32] = 32'h04; write = 2'b00;
        xfer(3, 48'h1234_5678, 1'b0, 1'b0, '0, seen, lat, a, wd, w, nsel, nen, dn, r, e, st);
        req = '0; ptr_m = 1;
        tests_run++; if (nen != 4 || nsel != 5) begin tests_failed++; $display("FAIL rd_wait: penable %0d psel %0d expected 4 5", nen, nsel); end
        tests_run++; if (a !== 32'h04 || w !== 1'b0) begin tests_failed++; $display("FAIL rd_addr: got %h %b expected 4 0", a, w); end
        tests_run++; if (dn !== 2'b10 || r !== 48'h1234_5678 || e !== 1'b0) begin tests_failed++; $display("FAIL rd_done: got %b %h %b expected 10 12345678 0", dn, r, e); end
    endtask

    task automatic test_back_to_back();
        logic seen, w, e, st; int lat, nsel, nen, win; logic [31:0] a; logic [47:0] wd, r, rd; logic [NREQ-1:0] dn;
        addr = {32'h200, 32'h100}; write = 2'b00; req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            win = rr_pick(ptr_m, req);
            rd = {16'($urandom), $urandom};
            xfer($urandom_range(0, 2), rd, 1'b0, 1'b0, '0, seen, lat, a, wd, w, nsel, nen, dn, r, e, st);
            ptr_m = win;
            tests_run++; if (dn !== ((t % 2 == 0) ? 2'b01 : 2'b10)) begin tests_failed++; $display("FAIL rr_order%0d: got %b expected %b", t, dn, (t % 2 == 0) ? 2'b01 : 2'b10); end
            tests_run++; if (a !== 32'(addr >> (32 * win)) || r !== rd) begin tests_failed++; $display("FAIL rr_data%0d: got %h %h expected %h %h", t, a, r, 32'(addr >> (32 * win)), rd); end
            if (t > 0) begin
                tests_run++; if (lat != 2) begin tests_failed++; $display("FAIL rr_gap%0d: got %0d expected 2", t, lat); end
            end
        end
        req = '0;
    endtask

    task automatic test_timeout();
        logic seen, w, e, st; int lat, nsel, nen; logic [31:0] a; logic [47:0] wd, r; logic [NREQ-1:0] dn;
        req = 2'b01; addr[31:0] = 32'h40; write = 2'b00;
        xfer(1000, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, '0, seen, lat, a, wd, w, nsel, nen, dn, r, e, st);
        ptr_m = 0;
        tests_run++; if (nen != TO) begin tests_failed++; $display("FAIL to_penable: got %0d expected %0d", nen, TO); end
        tests_run++; if (dn !== 2'b01 || e !== 1'b1 || r !== 48'd0) begin tests_failed++; $display("FAIL to_done: got %b %b %h expected 01 1 0", dn, e, r); end
        xfer(0, 48'h0000_CAFE_F00D, 1'b0, 1'b0, '0, seen, lat, a, wd, w, nsel, nen, dn, r, e, st);
        req = '0;
        tests_run++; if (dn !== 2'b01 || e !== 1'b0 || r !== 48'h0000_CAFE_F00D) begin tests_failed++; $display("FAIL to_recover: got %b %b %h expected 01 0 cafef00d", dn, e, r); end
    endtask

    task automatic test_slverr();
        logic seen, w, e, st; int lat, nsel, nen; logic [31:0] a; logic [47:0] wd, r; logic [NREQ-1:0] dn;
        req = 2'b10; addr[63:32] = 32'h1C; write = 2'b00;
        xfer(0, 48'h00DE_ADBE_EF00, 1'b1, 1'b0, '0, seen, lat, a, wd, w, nsel, nen, dn, r, e, st);
        req = '0; ptr_m = 1;
        tests_run++; if (a !== 32'h1C || dn !== 2'b10 || e !== 1'b1 || r !== 48'h00DE_ADBE_EF00) begin tests_failed++; $display("FAIL slverr: got %h %b %b %h expected 1c 10 1 deadbeef00", a, dn, e, r); end
    endtask

    task automatic test_reset_mid();
        logic seen, w, e, st; int lat, nsel, nen, guard, ndone; logic [31:0] a; logic [47:0] wd, r; logic [NREQ-1:0] dn;
        req = 2'b01; addr[31:0] = 32'h50; write = 2'b00; pready = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (penable !== 1'b1 && guard < 20);
        tests_run++; if (penable !== 1'b1) begin tests_failed++; $display("FAIL rstmid_access: got %b expected 1", penable); end
        rst = 1'b1;
        @(negedge clk);
        tests_run++; if ({psel, penable, busy} !== 3'b0 || done !== '0) begin tests_failed++; $display("FAIL rstmid_drop: got %b %b expected 000 00", {psel, penable, busy}, done); end
        rst = 1'b0; req = '0; ptr_m = NREQ - 1;
        ndone = 0;
        repeat (4) begin @(negedge clk); if (done !== '0) ndone++; end
        tests_run++; if (ndone != 0) begin tests_failed++; $display("FAIL rstmid_nodone: got %0d pulses expected 0", ndone); end
        req = 2'b11; addr = {32'h400, 32'h300};
        xfer(0, 48'h1, 1'b0, 1'b0, '0, seen, lat, a, wd, w, nsel, nen, dn, r, e, st);
        req = '0; ptr_m = 0;
        tests_run++; if (dn !== 2'b01 || a !== 32'h300) begin tests_failed++; $display("FAIL rstmid_regrant: got %b %h expected 01 300", dn, a); end
    endtask

    task automatic test_random();
        logic seen, w, e, st, serr, ew; int lat, nsel, nen, win, waits; logic [31:0] a, ea;
        logic [47:0] wd, r, rd, ewd; logic [NREQ-1:0] dn;
        for (int it = 0; it < 40; it++) begin
            req   = NREQ'($urandom_range(1, 3));
            addr  = {$urandom, $urandom};
            wdata = {$urandom, $urandom, $urandom};
            write = NREQ'($urandom);
            win   = rr_pick(ptr_m, req);
            ea    = 32'(addr >> (32 * win));
            ewd   = 48'(wdata >> (48 * win));
            ew    = 1'(write >> win);
            waits = $urandom_range(0, 10);
            rd    = {16'($urandom), $urandom};
            serr  = 1'($urandom);
            xfer(waits, rd, serr, 1'b1, NREQ'($urandom), seen, lat, a, wd, w, nsel, nen, dn, r, e, st);
            ptr_m = win;
            tests_run++; if (a !== ea || wd !== ewd || w !== ew || st !== 1'b1) begin tests_failed++; $display("FAIL rnd_payload%0d: got %h %h %b stable %b expected %h %h %b", it, a, wd, w, st, ea, ewd, ew); end
            tests_run++; if (dn !== (NREQ'(1) << win)) begin tests_failed++; $display("FAIL rnd_grant%0d: got %b expected %b", it, dn, NREQ'(1) << win); end
            tests_run++; if (nen != ((waits >= TO) ? TO : waits + 1)) begin tests_failed++; $display("FAIL rnd_wait%0d: got %0d expected %0d", it, nen, (waits >= TO) ? TO : waits + 1); end
            tests_run++; if (e !== ((waits >= TO) ? 1'b1 : serr) || r !== ((ew || waits >= TO) ? 48'd0 : rd)) begin tests_failed++; $display("FAIL rnd_resp%0d: got %b %h expected %b %h", it, e, r, (waits >= TO) ? 1'b1 : serr, (ew || waits >= TO) ? 48'd0 : rd); end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_wait_read();
        test_back_to_back();
        test_timeout();
        test_slverr();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
